round_sequencer: RTL
====================

# round_sequencer

Game-round controller that sits between the string generator, prompt LEDs, user-input listeners and the score/lives datapath. It stores the growing prompt sequence and plays it out at the rate-divider tick. It then checks user entries symbol-by-symbol against the sequence and issues one-cycle load/ALU commands to the score/lives datapath.

## Interface
- MAX_LEN, 16, maximum sequence length in symbols; the level counter width is $clog2(MAX_LEN+1), called LW below.
- ON_TICKS, 1, number of tick pulses each prompt stays lit.
- TIMEOUT_TICKS, 8, number of tick pulses allowed per entry; used only with the configuration macro.
- clock  in  1  single system clock; one clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request to begin a new game.
- tick  in  1  one-cycle enable from the rate divider.
- rand_sym  in  2  free-running random symbol, sampled in APPEND.
- user_valid  in  1  one-cycle strobe marking a user entry.
- user_sym  in  2  entered symbol, valid with user_valid.
- lives  in  4  current lives value from the datapath.
- ld_score, ld_lives, ld_alu_out  out  1 each  datapath load commands.
- alu_sel_a  out  2  ALU operand select: 0 = lives, 1 = score.
- alu_func  out  2  ALU function: 0 = +1, 1 = −1.
- prompt  out  3  0 = dark; 1..4 = symbol+1.
- level  out  LW  current sequence length.
- input_window  out  1  high while user entries are accepted.
- game_over  out  1  high in the OVER state.
- won  out  1  set when a round at MAX_LEN is cleared.

## Operation
- States: IDLE, INIT, APPEND, SHOW, GAP, WAIT_IN, SCORE, LIFE, LIFE_CHK, OVER.
- All outputs are Moore decodes of the registered state. Datapath commands default to 0.
- IDLE: start → INIT.
- INIT: assert ld_score=ld_lives=1 with ld_alu_out=0 (datapath loads score 0, lives 3). Clear level and won. → APPEND.
- APPEND: mem[level] ← rand_sym; level ← level+1; play index p ← 0. → SHOW.
- SHOW: prompt = mem[p]+1. After ON_TICKS tick pulses → GAP.
- GAP: prompt = 0. On the next tick: if p == level−1 then c ← 0 and → WAIT_IN; otherwise p ← p+1 and → SHOW.
- WAIT_IN: input_window = 1. user_valid is ignored in every other state.
  - user_valid and user_sym == mem[c]: if c == level−1 → SCORE, otherwise c ← c+1.
  - user_valid and a mismatch → LIFE.
- SCORE: ld_score=1, ld_alu_out=1, alu_sel_a=1, alu_func=0.
  - If level == MAX_LEN: set won and → OVER.
  - Otherwise → APPEND.
- LIFE: ld_lives=1, ld_alu_out=1, alu_sel_a=0, alu_func=1. → LIFE_CHK.
- LIFE_CHK: samples the lives value already updated by the datapath. lives == 0 → OVER. Otherwise p ← 0 and → SHOW, replaying the same sequence with no append.
- OVER: game_over = 1; start → INIT.
- start is ignored outside IDLE and OVER.
- Arithmetic: level, p and c are unsigned LW-bit values and never wrap; level saturates at MAX_LEN through the won path.

## Timing
- Reset values: state IDLE; level=0, p=0, c=0, won=0. Every output is 0: prompt, commands, input_window, game_over.
- Reset asserted in any state returns to IDLE on the next edge and overrides every other condition.
- Sequence memory is not cleared on reset; its contents are don't-care until rewritten.
- start → INIT on the next edge; INIT lasts 1 cycle, APPEND lasts 1 cycle.
- The first prompt is visible 3 cycles after the start strobe.
- Each displayed symbol takes ON_TICKS ticks in SHOW plus 1 tick in GAP.
- Entry-to-command latency: user_valid on the cycle it arrives in WAIT_IN → command cycle on the next edge.
- Each datapath command is exactly 1 cycle wide.
- LIFE_CHK lasts exactly 1 cycle after LIFE, so the datapath update is visible when lives is sampled.
- A tick pulse arriving in the same cycle as a state entry counts toward that state.

## Configuration
- Macro: ROUND_SEQ_TIMEOUT_EN.
- Defined: WAIT_IN counts ticks since entry or since the last correct symbol. Reaching TIMEOUT_TICKS with no user_valid → LIFE. If user_valid arrives in the same cycle as the final tick, user_valid wins.
- Undefined: WAIT_IN waits indefinitely. The timeout counter and the TIMEOUT_TICKS logic are absent.

## Structure
- Shared package: the state enum (4-bit), the ALU select constants (SEL_LIVES=0, SEL_SCORE=1), the ALU function constants (FUNC_INC=0, FUNC_DEC=1) and the prompt code for dark (0).
- Sub-module: seq_mem, an MAX_LEN×2 register array with one write port (APPEND) and two combinational read ports, indexed by p and c.

## Test plan
- Reset, then start with rand_sym=2 → one INIT cycle with ld_score=ld_lives=1 and ld_alu_out=0; then level=1 and prompt=3 for ON_TICKS ticks, followed by 0.
- Level 1, enter user_sym=2 → one cycle of ld_score=1, ld_alu_out=1, alu_sel_a=1, alu_func=0; level=2, and two symbols replay.
- Level 2, first entry wrong with a datapath model at lives=3 → one LIFE command cycle with lives model=2; same two symbols replay; level stays 2.
- Lives model at 1, wrong entry → LIFE then LIFE_CHK then OVER with game_over=1; a following start → INIT.
- MAX_LEN=4, clear four rounds → won=1 and game_over=1; no fifth APPEND occurs.
- ROUND_SEQ_TIMEOUT_EN defined, no input for 8 ticks → LIFE command. Undefined → no command after 100 ticks.
- Reset asserted mid-SHOW → prompt=0 and state IDLE on the next edge.

Source files
------------

// File: rtl/round_sequencer_pkg.sv
// round_sequencer_pkg: shared state encoding, datapath command constants and prompt helpers.
package round_sequencer_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_APPEND, S_SHOW, S_GAP, S_WAIT_IN, S_SCORE, S_LIFE, S_LIFE_CHK, S_OVER
  } state_t;
  localparam logic [1:0] SEL_LIVES = 2'd0;
  localparam logic [1:0] SEL_SCORE = 2'd1;
  localparam logic [1:0] FUNC_INC = 2'd0;
  localparam logic [1:0] FUNC_DEC = 2'd1;
  localparam logic [2:0] PROMPT_DARK = 3'd0;
  function automatic logic [2:0] prompt_code(input logic [1:0] sym);
    return {1'b0, sym} + 3'd1;
  endfunction
endpackage

// File: rtl/round_sequencer_seq_mem.sv
// seq_mem: prompt sequence storage, one write port and two combinational read ports; not reset.
module seq_mem #(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [1:0]    wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [1:0]    rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [1:0]    rdata_b
);
  logic [1:0] mem [DEPTH];
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/round_sequencer.sv
// round_sequencer: game-round FSM that grows, plays out and checks the prompt sequence.
// Optional ROUND_SEQ_TIMEOUT_EN adds a per-entry tick timeout in WAIT_IN.
module round_sequencer
  import round_sequencer_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int ON_TICKS = 1
`ifdef ROUND_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_TICKS = 8
`endif
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           tick,
  input  logic [1:0]                     rand_sym,
  input  logic                           user_valid,
  input  logic [1:0]                     user_sym,
  input  logic [3:0]                     lives,
  output logic                           ld_score,
  output logic                           ld_lives,
  output logic                           ld_alu_out,
  output logic [1:0]                     alu_sel_a,
  output logic [1:0]                     alu_func,
  output logic [2:0]                     prompt,
  output logic [$clog2(MAX_LEN+1)-1:0]   level,
  output logic                           input_window,
  output logic                           game_over,
  output logic                           won
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
  localparam int OW = ON_TICKS > 1 ? $clog2(ON_TICKS) : 1;
  state_t state, state_d;
  logic [LW-1:0] level_d, p, p_d, c, c_d;
  logic [OW-1:0] on_cnt, on_d;
  logic won_d;
  logic [1:0] mem_p, mem_c;
`ifdef ROUND_SEQ_TIMEOUT_EN
  localparam int TW = TIMEOUT_TICKS > 1 ? $clog2(TIMEOUT_TICKS) : 1;
  logic [TW-1:0] to_cnt, to_d;
`endif
  seq_mem #(.DEPTH(MAX_LEN), .AW(AW)) u_mem (
    .clock   (clock),
    .we      (state == S_APPEND),
    .waddr   (level[AW-1:0]),
    .wdata   (rand_sym),
    .raddr_a (p[AW-1:0]),
    .rdata_a (mem_p),
    .raddr_b (c[AW-1:0]),
    .rdata_b (mem_c)
  );
  always_comb begin
    state_d = state;
    level_d = level;
    p_d = p;
    c_d = c;
    won_d = won;
    on_d = on_cnt;
`ifdef ROUND_SEQ_TIMEOUT_EN
    to_d = '0;
`endif
    case (state)
      S_IDLE: state_d = start ? S_INIT : S_IDLE;
      S_INIT: begin
        level_d = '0;
        won_d = 1'b0;
        state_d = S_APPEND;
      end
      S_APPEND: begin
        level_d = level + LW'(1);
        p_d = '0;
        on_d = '0;
        state_d = S_SHOW;
      end
      S_SHOW:
        if (tick) begin
          if (on_cnt == OW'(ON_TICKS - 1)) state_d = S_GAP;
          else on_d = on_cnt + OW'(1);
        end
      S_GAP:
        if (tick) begin
          if (p == level - LW'(1)) begin
            c_d = '0;
            state_d = S_WAIT_IN;
          end else begin
            p_d = p + LW'(1);
            on_d = '0;
            state_d = S_SHOW;
          end
        end
      S_WAIT_IN: begin
`ifdef ROUND_SEQ_TIMEOUT_EN
        to_d = to_cnt;
`endif
        if (user_valid) begin
          if (user_sym != mem_c) state_d = S_LIFE;
          else if (c == level - LW'(1)) state_d = S_SCORE;
          else begin
            c_d = c + LW'(1);
`ifdef ROUND_SEQ_TIMEOUT_EN
            to_d = '0;
`endif
          end
        end
`ifdef ROUND_SEQ_TIMEOUT_EN
        else if (tick) begin
          if (to_cnt == TW'(TIMEOUT_TICKS - 1)) state_d = S_LIFE;
          else to_d = to_cnt + TW'(1);
        end
`endif
      end
      S_SCORE:
        if (level == LW'(MAX_LEN)) begin
          won_d = 1'b1;
          state_d = S_OVER;
        end else state_d = S_APPEND;
      S_LIFE: state_d = S_LIFE_CHK;
      S_LIFE_CHK:
        if (lives == 4'd0) state_d = S_OVER;
        else begin
          p_d = '0;
          on_d = '0;
          state_d = S_SHOW;
        end
      S_OVER: state_d = start ? S_INIT : S_OVER;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      level <= '0;
      p <= '0;
      c <= '0;
      won <= 1'b0;
      on_cnt <= '0;
`ifdef ROUND_SEQ_TIMEOUT_EN
      to_cnt <= '0;
`endif
    end else begin
      state <= state_d;
      level <= level_d;
      p <= p_d;
      c <= c_d;
      won <= won_d;
      on_cnt <= on_d;
`ifdef ROUND_SEQ_TIMEOUT_EN
      to_cnt <= to_d;
`endif
    end
  end
  assign ld_score = state == S_INIT || state == S_SCORE;
  assign ld_lives = state == S_INIT || state == S_LIFE;
  assign ld_alu_out = state == S_SCORE || state == S_LIFE;
  assign alu_sel_a = state == S_SCORE ? SEL_SCORE : SEL_LIVES;
  assign alu_func = state == S_LIFE ? FUNC_DEC : FUNC_INC;
  assign prompt = state == S_SHOW ? prompt_code(mem_p) : PROMPT_DARK;
  assign input_window = state == S_WAIT_IN;
  assign game_over = state == S_OVER;
endmodule
